// File: rtl/core_sequencer.sv
// Fetch/decode/execute controller: fetches a 20-bit word over req/ack and issues one core_step per instruction.
// Optional single-step mode (PAUSE state and step input) is enabled by defining SEQ_SINGLE_STEP_EN.
module core_sequencer #(
  parameter int IW      = 20,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    pc,
  output logic          ifetch_req,
  output logic [7:0]    ifetch_addr,
  input  logic          ifetch_ack,
  input  logic [IW-1:0] ifetch_data,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic          core_step,
  output logic          mem_inst,
  output logic          alu_inst,
  output logic          jmp_inst,
  output logic          irs,
  output logic          ms1,
  output logic          ms0,
  output logic [2:0]    rs,
  output logic [2:0]    ar,
  output logic [2:0]    bs,
  output logic [3:0]    op,
  output logic [7:0]    imm,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [15:0]   icount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT,
    S_FAULT
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        halt_pend_q, halt_pend_d;
  logic [15:0] icount_q, icount_d;
  logic        req_q, req_d;
  logic [7:0]  addr_q, addr_d;
  logic        step_q, step_d;
  logic        mem_q, mem_d;
  logic        alu_q, alu_d;
  logic        jmp_q, jmp_d;
  logic        irs_q, irs_d;
  logic [1:0]  ms_q, ms_d;
  logic [2:0]  rs_q, rs_d;
  logic [2:0]  ar_q, ar_d;
  logic [2:0]  bs_q, bs_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  imm_q, imm_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  logic [1:0] cls;
  logic [3:0] op_f;
  logic [2:0] rd_f;
  logic [2:0] rb_f;
  logic [7:0] imm_f;
  logic       halt_word;

  assign cls       = ifetch_data[19:18];
  assign op_f      = ifetch_data[17:14];
  assign rd_f      = ifetch_data[13:11];
  assign rb_f      = ifetch_data[10:8];
  assign imm_f     = ifetch_data[7:0];
  assign halt_word = (cls == 2'b11) && (rd_f == 3'b111);

  // Controls are decoded straight into their output flops on the WAIT->EXEC edge,
  // so they are valid for exactly the EXEC cycle and zero everywhere else.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    halt_pend_d = halt_pend_q;
    icount_d    = icount_q;
    addr_d      = addr_q;
    step_d      = 1'b0;
    mem_d       = 1'b0;
    alu_d       = 1'b0;
    jmp_d       = 1'b0;
    irs_d       = 1'b0;
    ms_d        = 2'b00;
    rs_d        = 3'b000;
    ar_d        = 3'b000;
    bs_d        = 3'b000;
    op_d        = 4'h0;
    imm_d       = 8'h00;

    case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = pc;
        end
      end
      S_FETCH: begin
        state_d    = S_WAIT;
        wait_cnt_d = 4'd0;
      end
      S_WAIT: begin
        if (ifetch_ack) begin
          state_d     = S_EXEC;
          halt_pend_d = halt_word;
          if (!halt_word) begin
            step_d   = 1'b1;
            icount_d = icount_q + 16'd1;
          end
          case (cls)
            2'b00, 2'b01: begin
              alu_d = 1'b1;
              irs_d = cls[0];
              rs_d  = rd_f;
              ar_d  = rd_f;
              bs_d  = rb_f;
              op_d  = op_f;
              imm_d = imm_f;
            end
            2'b10: begin
              if (op_f[1:0] != 2'b00) begin
                mem_d = 1'b1;
                ms_d  = op_f[1:0];
                rs_d  = rd_f;
                ar_d  = rb_f;
                imm_d = imm_f;
              end
            end
            default: begin
              if (rd_f == 3'b000) begin
                jmp_d = 1'b1;
                op_d  = op_f;
                imm_d = imm_f;
              end
            end
          endcase
        end else if (wait_cnt_q == 4'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_EXEC: begin
        if (halt_pend_q) begin
          state_d = S_HALT;
        end else begin
`ifdef SEQ_SINGLE_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
          addr_d  = pc;
`endif
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) begin
          state_d = S_FETCH;
          addr_d  = pc;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    req_d    = (state_d == S_FETCH) || (state_d == S_WAIT);
    halted_d = (state_d == S_HALT);
    err_d    = (state_d == S_FAULT);
`ifdef SEQ_SINGLE_STEP_EN
    busy_d   = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_EXEC) ||
               (state_d == S_PAUSE);
`else
    busy_d   = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_EXEC);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      halt_pend_q <= 1'b0;
      icount_q    <= 16'd0;
      req_q       <= 1'b0;
      addr_q      <= 8'h00;
      step_q      <= 1'b0;
      mem_q       <= 1'b0;
      alu_q       <= 1'b0;
      jmp_q       <= 1'b0;
      irs_q       <= 1'b0;
      ms_q        <= 2'b00;
      rs_q        <= 3'b000;
      ar_q        <= 3'b000;
      bs_q        <= 3'b000;
      op_q        <= 4'h0;
      imm_q       <= 8'h00;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      halt_pend_q <= halt_pend_d;
      icount_q    <= icount_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      step_q      <= step_d;
      mem_q       <= mem_d;
      alu_q       <= alu_d;
      jmp_q       <= jmp_d;
      irs_q       <= irs_d;
      ms_q        <= ms_d;
      rs_q        <= rs_d;
      ar_q        <= ar_d;
      bs_q        <= bs_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  assign ifetch_req  = req_q;
  assign ifetch_addr = addr_q;
  assign core_step   = step_q;
  assign mem_inst    = mem_q;
  assign alu_inst    = alu_q;
  assign jmp_inst    = jmp_q;
  assign irs         = irs_q;
  assign ms1         = ms_q[1];
  assign ms0         = ms_q[0];
  assign rs          = rs_q;
  assign ar          = ar_q;
  assign bs          = bs_q;
  assign op          = op_q;
  assign imm         = imm_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign icount      = icount_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: expected EXEC results are queued when a word is acked
// and popped when the core_step pulse appears; flag, timeout and reset behaviour checked inline.
module tb_core_sequencer;

  logic        clock;
  logic        rstN;
  logic        start;
  logic [7:0]  pc;
  logic        ifetchReq;
  logic [7:0]  ifetchAddr;
  logic        ifetchAck;
  logic [19:0] ifetchData;
  logic        step;
  logic        coreStep, memInst, aluInst, jmpInst, irs, ms1, ms0;
  logic [2:0]  rs, ar, bs;
  logic [3:0]  op;
  logic [7:0]  imm;
  logic        busy, halted, err;
  logic [15:0] icount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        mem, alu, jmp, irs;
    logic [1:0]  ms;
    logic [2:0]  rs, ar, bs;
    logic [3:0]  op;
    logic [7:0]  imm;
    logic [15:0] icount;
    bit          chkSel, chkBs, chkOp, chkImm;
  } execExp_t;

  execExp_t sb[$];

  core_sequencer dut (
    .clk        (clock),
    .rst_n      (rstN),
    .start      (start),
    .pc         (pc),
    .ifetch_req (ifetchReq),
    .ifetch_addr(ifetchAddr),
    .ifetch_ack (ifetchAck),
    .ifetch_data(ifetchData),
`ifdef SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .core_step  (coreStep),
    .mem_inst   (memInst),
    .alu_inst   (aluInst),
    .jmp_inst   (jmpInst),
    .irs        (irs),
    .ms1        (ms1),
    .ms0        (ms0),
    .rs         (rs),
    .ar         (ar),
    .bs         (bs),
    .op         (op),
    .imm        (imm),
    .busy       (busy),
    .halted     (halted),
    .err        (err),
    .icount     (icount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [19:0] d);
    start      = s;
    ifetchAck  = a;
    ifetchData = d;
  endtask

  function automatic execExp_t mkExp(input string tag, input logic mem, input logic alu,
                                     input logic jmp, input logic irsV, input logic [1:0] ms,
                                     input logic [2:0] rsV, input logic [2:0] arV,
                                     input logic [2:0] bsV, input logic [3:0] opV,
                                     input logic [7:0] immV, input logic [15:0] cnt,
                                     input bit chkSel, input bit chkBs, input bit chkOp,
                                     input bit chkImm);
    execExp_t e;
    e.tag = tag; e.mem = mem; e.alu = alu; e.jmp = jmp; e.irs = irsV; e.ms = ms;
    e.rs = rsV; e.ar = arV; e.bs = bsV; e.op = opV; e.imm = immV; e.icount = cnt;
    e.chkSel = chkSel; e.chkBs = chkBs; e.chkOp = chkOp; e.chkImm = chkImm;
    return e;
  endfunction

  // Acks a word in the current WAIT cycle and records what EXEC must look like.
  task automatic ackWord(input logic [19:0] word, input execExp_t e);
    sb.push_back(e);
    applyStimulus(1'b0, 1'b1, word);
    tick;
    applyStimulus(1'b0, 1'b0, 20'h0);
  endtask

  task automatic checkExec;
    int n = 0;
    execExp_t e;
    while (coreStep !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checkOutput("execStepSeen", coreStep, 1'b1);
    checkOutput("scoreboardNotEmpty", sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, ".class"}, {memInst, aluInst, jmpInst, irs}, {e.mem, e.alu, e.jmp, e.irs});
      checkOutput({e.tag, ".ms"}, {ms1, ms0}, e.ms);
      checkOutput({e.tag, ".icount"}, icount, e.icount);
      checkOutput({e.tag, ".busy"}, {busy, ifetchReq}, 2'b10);
      if (e.chkSel) checkOutput({e.tag, ".rsAr"}, {rs, ar}, {e.rs, e.ar});
      if (e.chkBs)  checkOutput({e.tag, ".bs"}, bs, e.bs);
      if (e.chkOp)  checkOutput({e.tag, ".op"}, op, e.op);
      if (e.chkImm) checkOutput({e.tag, ".imm"}, imm, e.imm);
    end
  endtask

  task automatic finishExec(input string tag, input logic [7:0] nextPc);
    pc = nextPc;
    tick;
    checkOutput({tag, ".onePulse"}, {coreStep, memInst, aluInst, jmpInst, op, imm}, 64'h0);
`ifdef SEQ_SINGLE_STEP_EN
    for (int i = 0; i < 10; i++) begin
      checkOutput({tag, ".pauseHold"}, {ifetchReq, busy}, 2'b01);
      tick;
    end
    step = 1'b1;
    tick;
    step = 1'b0;
`endif
    checkOutput({tag, ".refetch"}, {ifetchReq, ifetchAddr}, {1'b1, nextPc});
  endtask

  initial begin
    int n;
    rstN = 1'b0;
    step = 1'b0;
    pc   = 8'h00;
    applyStimulus(1'b0, 1'b0, 20'h0);
    tick;
    tick;
    applyStimulus(1'b0, 1'b1, {2'b10, 4'b0010, 3'b000, 3'b000, 8'd10});
    tick;
    checkOutput("resetOutputs",
                {ifetchReq, ifetchAddr, coreStep, memInst, aluInst, jmpInst, irs, ms1, ms0,
                 rs, ar, bs, op, imm, busy, halted, err, icount}, 64'h0);

    rstN = 1'b1;
    tick;
    checkOutput("lateAckIdle", {ifetchReq, busy, coreStep}, 3'b000);
    applyStimulus(1'b0, 1'b0, 20'h0);

    pc = 8'h10;
    applyStimulus(1'b1, 1'b0, 20'h0);
    tick;
    applyStimulus(1'b0, 1'b0, 20'h0);
    checkOutput("startFetch", {ifetchReq, ifetchAddr, busy}, {1'b1, 8'h10, 1'b1});

    tick;
    ackWord({2'b10, 4'b0010, 3'b000, 3'b000, 8'd10},
            mkExp("movFirstWait", 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 8'd10, 16'd1, 1, 0, 0, 1));
    checkExec();
    finishExec("movFirstWait", 8'h11);

    tick;
    for (int i = 0; i < 3; i++) begin
      checkOutput("aluWaitReqHeld", {ifetchReq, coreStep}, 2'b10);
      tick;
    end
    ackWord({2'b01, 4'b1000, 3'b000, 3'b000, 8'd5},
            mkExp("aluImm", 0, 1, 0, 1, 2'b00, 0, 0, 0, 4'd8, 8'd5, 16'd2, 1, 1, 1, 1));
    checkExec();
    finishExec("aluImm", 8'h12);

    tick;
    ackWord({2'b00, 4'b0101, 3'b011, 3'b110, 8'hAA},
            mkExp("aluReg", 0, 1, 0, 0, 2'b00, 3'd3, 3'd3, 3'd6, 4'd5, 8'h00, 16'd3, 1, 1, 1, 0));
    checkExec();
    finishExec("aluReg", 8'h13);

    tick;
    ackWord({2'b10, 4'b0111, 3'b011, 3'b101, 8'h5A},
            mkExp("movSel", 1, 0, 0, 0, 2'b11, 3'd3, 3'd5, 0, 0, 8'h5A, 16'd4, 1, 0, 0, 1));
    checkExec();
    finishExec("movSel", 8'h14);

    tick;
    ackWord({2'b10, 4'b1100, 3'b010, 3'b001, 8'hFF},
            mkExp("movNop", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 8'h00, 16'd5, 1, 1, 1, 1));
    checkExec();
    finishExec("movNop", 8'h15);

    tick;
    ackWord({2'b11, 4'b0011, 3'b000, 3'b010, 8'h44},
            mkExp("jmp", 0, 0, 1, 0, 2'b00, 0, 0, 0, 4'd3, 8'h44, 16'd6, 0, 0, 1, 1));
    checkExec();
    finishExec("jmp", 8'h16);

    tick;
    ackWord({2'b11, 4'b1111, 3'b101, 3'b111, 8'h99},
            mkExp("cls3Nop", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 8'h00, 16'd7, 1, 1, 1, 1));
    checkExec();
    finishExec("cls3Nop", 8'h17);

    // ACK on the fifteenth WAIT cycle still wins over the timeout
    tick;
    for (int i = 0; i < 14; i++) tick;
    checkOutput("lastWaitReq", {ifetchReq, err}, 2'b10);
    ackWord({2'b00, 4'b0001, 3'b001, 3'b010, 8'h00},
            mkExp("lastWaitAck", 0, 1, 0, 0, 2'b00, 3'd1, 3'd1, 3'd2, 4'd1, 8'h00, 16'd8, 1, 1, 1, 0));
    checkExec();
    finishExec("lastWaitAck", 8'h18);

    tick;
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checkOutput("timeoutCycles", n, 15);
    checkOutput("faultFlags", {err, ifetchReq, busy, coreStep}, 4'b1000);

    pc = 8'h20;
    applyStimulus(1'b1, 1'b0, 20'h0);
    tick;
    applyStimulus(1'b0, 1'b0, 20'h0);
    checkOutput("faultRestart", {err, ifetchReq, ifetchAddr}, {1'b0, 1'b1, 8'h20});

    applyStimulus(1'b0, 1'b1, {2'b00, 4'b0001, 3'b001, 3'b010, 8'h00});
    tick;
    applyStimulus(1'b1, 1'b0, 20'h0);
    checkOutput("ackInFetchIgnored", {ifetchReq, coreStep, busy, icount}, {3'b101, 16'd8});
    tick;
    applyStimulus(1'b0, 1'b0, 20'h0);
    checkOutput("startWhileBusy", {ifetchReq, busy, halted, err}, 4'b1100);

    applyStimulus(1'b0, 1'b1, {2'b11, 4'b0000, 3'b111, 3'b000, 8'h00});
    tick;
    applyStimulus(1'b0, 1'b0, 20'h0);
    checkOutput("haltExec", {coreStep, busy, halted, icount}, {3'b010, 16'd8});
    tick;
    checkOutput("haltState", {coreStep, busy, halted, ifetchReq, icount}, {4'b0010, 16'd8});
    tick;
    checkOutput("haltStays", {halted, coreStep, icount}, {2'b10, 16'd8});
    pc = 8'h33;
    applyStimulus(1'b1, 1'b0, 20'h0);
    tick;
    applyStimulus(1'b0, 1'b0, 20'h0);
    checkOutput("haltRestart", {halted, ifetchReq, ifetchAddr}, {2'b01, 8'h33});

    tick;
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("asyncResetDropsReq", {ifetchReq, busy, icount}, 18'h0);
    applyStimulus(1'b0, 1'b1, {2'b01, 4'b1000, 3'b000, 3'b000, 8'd5});
    tick;
    rstN = 1'b1;
    tick;
    checkOutput("lateAckAfterReset", {ifetchReq, coreStep, busy, aluInst}, 4'b0000);
    applyStimulus(1'b0, 1'b0, 20'h0);
    tick;
    checkOutput("stillIdle", {ifetchReq, busy, icount}, 18'h0);

    checkOutput("scoreboardDrained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
